// File: rtl/conf_int_mac_dot_seq.sv
// Dot-product sequencer: feeds operand pairs and a registered accumulator to an external combinational MAC.
// Result is valid the cycle after the last operand handshake. DONE holds the result until out_ready.
// Defining CONF_MAC_DOT_SEQ_OVF_EN adds the sticky out_ovf flag.
module conf_int_mac_dot_seq #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int LEN_BITWIDTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_BITWIDTH-1:0]       cfg_len,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_a,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_b,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_c,
    input  logic [DATA_PATH_BITWIDTH-1:0] mac_d,
`ifdef CONF_MAC_DOT_SEQ_OVF_EN
    output logic                          out_ovf,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] out_data
);

    // OP_BITWIDTH only configures the external MAC; it is carried here for reference.
    localparam int UNUSED_OP_BITWIDTH = OP_BITWIDTH;
    localparam logic [LEN_BITWIDTH-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [DATA_PATH_BITWIDTH-1:0]   acc_q,   acc_d;
    logic [LEN_BITWIDTH-1:0]         cnt_q,   cnt_d;
    logic [LEN_BITWIDTH-1:0]         len_q,   len_d;
    logic                            in_hs;

    assign mac_a    = in_a;
    assign mac_b    = in_b;
    assign mac_c    = acc_q;
    assign out_data = acc_q;

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign in_hs     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (cfg_len != '0) begin
                        len_d   = cfg_len;
                        cnt_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (in_hs) begin
                    acc_d = mac_d;
                    cnt_d = cnt_q + LEN_ONE;
                    if (cnt_q == len_q - LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A start arriving together with out_ready is deliberately dropped.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

`ifdef CONF_MAC_DOT_SEQ_OVF_EN
    localparam int SHW = 2*DATA_PATH_BITWIDTH + 1;

    logic           ovf_q, ovf_d;
    logic [SHW-1:0] shadow;

    // Unwrapped a*b+acc; any bit at or above DATA_PATH_BITWIDTH means the MAC result wrapped.
    always_comb begin
        shadow = SHW'(in_a) * SHW'(in_b) + SHW'(acc_q);
        ovf_d  = ovf_q;
        if ((state_q == S_IDLE) && start) begin
            ovf_d = 1'b0;
        end else if (in_hs && (|shadow[SHW-1:DATA_PATH_BITWIDTH])) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_conf_int_mac_dot_seq.sv
// Directed bench for conf_int_mac_dot_seq with a behavioural combinational MAC.
module tb_conf_int_mac_dot_seq;

    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] cfg_len;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a, in_b;
    logic [DW-1:0] mac_a, mac_b, mac_c, mac_d;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef CONF_MAC_DOT_SEQ_OVF_EN
    logic          out_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // External MAC: d = a*b + c modulo 2^DW
    assign mac_d = DW'(mac_a * mac_b + mac_c);

    conf_int_mac_dot_seq #(
        .OP_BITWIDTH(16),
        .DATA_PATH_BITWIDTH(DW),
        .LEN_BITWIDTH(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_len(cfg_len),
        .busy(busy),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .mac_a(mac_a),
        .mac_b(mac_b),
        .mac_c(mac_c),
        .mac_d(mac_d),
`ifdef CONF_MAC_DOT_SEQ_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic launch(input logic [LW-1:0] len);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;

        // Reset and idle behaviour
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        in_valid = 1'b1; in_a = 16'd5; in_b = 16'd5;
        tick(); tick();
        in_valid = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_out_data", out_data, 0);
        chk("idle_out_valid", out_valid, 0);

        // Basic run, continuous valid: 2*3 + 4*5 + 1*7 = 33
        out_ready = 1'b1;
        launch(8'd3);
        chk("basic_busy0", busy, 1);
        chk("basic_in_ready", in_ready, 1);
        chk("basic_mac_c0", mac_c, 0);
        feed(16'd2, 16'd3);
        chk("basic_acc1", out_data, 6);
        chk("basic_ov1", out_valid, 0);
        feed(16'd4, 16'd5);
        chk("basic_acc2", out_data, 26);
        chk("basic_busy2", busy, 1);
        feed(16'd1, 16'd7);
        chk("basic_out_valid", out_valid, 1);
        chk("basic_out_data", out_data, 33);
        chk("basic_in_ready_done", in_ready, 0);
`ifdef CONF_MAC_DOT_SEQ_OVF_EN
        chk("basic_ovf", out_ovf, 0);
`endif
        tick();
        chk("basic_idle_busy", busy, 0);
        chk("basic_idle_ov", out_valid, 0);
        chk("basic_acc_kept", out_data, 33);

        // Stalls and back-pressure
        out_ready = 1'b0;
        launch(8'd3);
        tick();
        chk("stall_hold0", out_data, 0);
        feed(16'd2, 16'd3);
        tick();
        chk("stall_hold1", out_data, 6);
        chk("stall_in_ready", in_ready, 1);
        feed(16'd4, 16'd5);
        tick();
        feed(16'd1, 16'd7);
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 33);
            tick();
        end
        chk("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_busy", busy, 0);
        chk("bp_release_ov", out_valid, 0);

        // Zero length goes straight to DONE with result 0
        launch(8'd0);
        chk("zero_out_valid", out_valid, 1);
        chk("zero_out_data", out_data, 0);
        chk("zero_busy", busy, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("zero_release", busy, 0);

        // Start pulses during ACCUM are ignored: 3*4 + 2*2 = 16
        launch(8'd2);
        start = 1'b1; cfg_len = 8'd5;
        feed(16'd3, 16'd4);
        chk("ign_acc1", out_data, 12);
        chk("ign_ov1", out_valid, 0);
        feed(16'd2, 16'd2);
        start = 1'b0;
        chk("ign_out_valid", out_valid, 1);
        chk("ign_out_data", out_data, 16);

        // Start with out_ready in DONE: back to IDLE only
        start = 1'b1; out_ready = 1'b1; cfg_len = 8'd2;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("done_start_busy", busy, 0);
        chk("done_start_in_ready", in_ready, 0);
        chk("done_start_data", out_data, 16);

        // Wrap-around: 0xFFFF*2 = 0xFFFE, + 1*3 = 0x10001 -> 0x0001
        launch(8'd2);
        chk("wrap_cleared", out_data, 0);
        feed(16'hFFFF, 16'd2);
        chk("wrap_acc1", out_data, 16'hFFFE);
        feed(16'd1, 16'd3);
        chk("wrap_out_valid", out_valid, 1);
        chk("wrap_out_data", out_data, 16'h0001);
`ifdef CONF_MAC_DOT_SEQ_OVF_EN
        chk("wrap_ovf", out_ovf, 1);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-run aborts silently
        launch(8'd4);
`ifdef CONF_MAC_DOT_SEQ_OVF_EN
        chk("ovf_clear_on_start", out_ovf, 0);
`endif
        feed(16'd1, 16'd1);
        feed(16'd1, 16'd1);
        chk("mid_acc2", out_data, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", out_data, 0);
        in_valid = 1'b1; in_a = 16'd1; in_b = 16'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_ov", out_valid, 0);
        end
        in_valid = 1'b0;

        // Fresh single-term run: 6*7 = 42
        launch(8'd1);
        chk("single_busy", busy, 1);
        feed(16'd6, 16'd7);
        chk("single_out_valid", out_valid, 1);
        chk("single_out_data", out_data, 42);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_release", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/conf_int_mac_dot_seq.md
Name: conf_int_mac_dot_seq

Overview:
- Sequencer that drives the shared combinational integer MAC (d = a*b + c_in) to compute an N-term dot product.
- Accepts a run length, streams operand pairs through a valid/ready handshake and feeds back a registered accumulator as c_in.
- Presents the final sum on a valid/ready output.
- The MAC stays external; this block owns only control and the accumulator flop.

Parameters:
- OP_BITWIDTH, 16, operator bit width forwarded to the MAC configuration; informational here.
- DATA_PATH_BITWIDTH, 16, width of operands, accumulator and result.
- LEN_BITWIDTH, 8, width of the run-length field; max run = 2^LEN_BITWIDTH-1 terms.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse; begins a run; sampled only in IDLE.
- cfg_len  input  LEN_BITWIDTH  number of terms; sampled with start.
- busy  output  1  high in ACCUM and DONE.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operand pair.
- in_a  input  DATA_PATH_BITWIDTH  operand a.
- in_b  input  DATA_PATH_BITWIDTH  operand b.
- mac_a  output  DATA_PATH_BITWIDTH  to MAC a.
- mac_b  output  DATA_PATH_BITWIDTH  to MAC b.
- mac_c  output  DATA_PATH_BITWIDTH  to MAC c_in.
- mac_d  input  DATA_PATH_BITWIDTH  from MAC d.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  DATA_PATH_BITWIDTH  dot-product result.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, acc=0, cnt=0, len_q=0. Outputs busy=0, in_ready=0, out_valid=0, out_data=0.
- Reset mid-run aborts the run silently; no out_valid is produced.
- Datapath wiring, combinational: mac_a=in_a, mac_b=in_b, mac_c=acc, out_data=acc. The MAC is combinational, so mac_d is consumed in the same cycle.
- Arithmetic is unsigned, modulo 2^DATA_PATH_BITWIDTH; wrap-around is silent.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with cfg_len!=0: len_q<=cfg_len, acc<=0, cnt<=0, go to ACCUM.
  - start=1 with cfg_len==0: acc<=0, go directly to DONE (result 0).
- State ACCUM:
  - in_ready=1.
  - On handshake (in_valid & in_ready): acc<=mac_d and cnt<=cnt+1.
  - If cnt==len_q-1 at the handshake, go to DONE.
  - No handshake: hold all state.
- State DONE:
  - out_valid=1, in_ready=0.
  - out_ready=1: go to IDLE; acc keeps the last result until the next start.
  - Back-pressure: out_valid stays high and out_data stays stable.
- start outside IDLE is ignored; the run continues unaffected.
- start and out_ready in the same DONE cycle: return to IDLE only; start is not captured. A new run needs a start in IDLE.
- Latency: a result is valid the cycle after the last operand handshake. Minimum run time is len+1 cycles with continuous in_valid and out_ready.
- cnt is LEN_BITWIDTH wide and never wraps, since cnt<len_q<=2^LEN_BITWIDTH-1.

Optional Feature:
- Macro CONF_MAC_DOT_SEQ_OVF_EN adds output out_ovf (1 bit).
- With the macro:
  - An internal shadow computes in_a*in_b+acc at full 2*DATA_PATH_BITWIDTH+1 width on each handshake.
  - A sticky flag sets if that value is >= 2^DATA_PATH_BITWIDTH.
  - The flag clears on reset and on an accepted start, and is valid alongside out_valid.
- Without the macro: no out_ovf port and no extra logic; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst for 2 cycles -> busy=0, in_ready=0, out_valid=0, out_data=0; no change with in_valid=1 while IDLE.
- Basic run: cfg_len=3, pairs (2,3),(4,5),(1,7) with continuous valid -> out_valid one cycle after the 3rd handshake, out_data=33, busy=1 throughout.
- Stalls and back-pressure: same run with in_valid low every other cycle and out_ready held low for 4 cycles in DONE -> result still 33, out_data stable, out_valid held, returns to IDLE on the out_ready cycle.
- Zero length and ignored start: cfg_len=0 start -> DONE next cycle with out_data=0. Then start pulses during an ACCUM run with cfg_len=2 -> ignored, result unchanged.
- Wrap-around: DATA_PATH_BITWIDTH=16, cfg_len=2, pairs (0xFFFF,2),(1,3) -> out_data=0x0001. With CONF_MAC_DOT_SEQ_OVF_EN, out_ovf=1.
- Reset mid-run: cfg_len=4, assert rst after 2 handshakes -> IDLE next edge, acc=0, no out_valid. A following run with cfg_len=1, pair (6,7) -> out_data=42.
